// File: rtl/ydevice_pkg.sv
// rtl/ydevice_pkg.sv - state encoding and LFSR constants shared by ydevice_rx and ydevice_seqchk
package ydevice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions of a right-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/ydevice_seqchk.sv
// rtl/ydevice_seqchk.sv - incrementing-sequence checker with saturating error count and sticky flag
module ydevice_seqchk
  import ydevice_pkg::*;
#(
  parameter int DW        = 4,
  parameter int CW        = 8,
  parameter bit SEQ_CHECK = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cap,
  input  logic [DW-1:0] dat,
  output logic [CW-1:0] err_cnt,
  output logic          err_flag
);

  logic [DW-1:0] exp_dat;
  logic          seq_valid;

  // exp_dat is always reloaded from the captured word, so one bad word costs one error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_dat   <= '0;
      seq_valid <= 1'b0;
      err_cnt   <= '0;
      err_flag  <= 1'b0;
    end else if (cap) begin
      exp_dat   <= dat + 1'b1;
      seq_valid <= 1'b1;
      if (SEQ_CHECK && seq_valid && (dat != exp_dat)) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ydevice_rx.sv
// rtl/ydevice_rx.sv - dummy Y-port receiver: ack pulse, capture, counters; YDEVICE_RX_RANDOM_STALL_EN adds LFSR stalls
module ydevice_rx
  import ydevice_pkg::*;
#(
  parameter int DW        = 4,
  parameter int CW        = 8,
  parameter bit SEQ_CHECK = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          validrx,
  input  logic [DW-1:0] dat_o,
  output logic          ackrx,
  input  logic          hold_i,
  output logic [DW-1:0] last_dat,
  output logic [CW-1:0] rx_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          err_flag
);

  state_t state, state_nxt;
  logic   cap;
  logic   stall;

`ifdef YDEVICE_RX_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ACK and GAP ignore validrx/hold_i so a started pulse always completes.
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (validrx && !hold_i && !stall) begin
          cap       = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      ackrx    <= 1'b0;
      last_dat <= '0;
      rx_cnt   <= '0;
    end else begin
      state <= state_nxt;
      ackrx <= cap;
      if (cap) begin
        last_dat <= dat_o;
        if (rx_cnt != '1) rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  ydevice_seqchk #(
    .DW       (DW),
    .CW       (CW),
    .SEQ_CHECK(SEQ_CHECK)
  ) u_seqchk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .cap     (cap),
    .dat     (dat_o),
    .err_cnt (err_cnt),
    .err_flag(err_flag)
  );

endmodule

// File: tb/tb_ydevice_rx.sv
// tb/tb_ydevice_rx.sv - self-checking bench for ydevice_rx with a behavioural receive model
module tb_ydevice_rx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       validrx = 1'b0;
  logic [3:0] dat_o = 4'h0;
  logic       hold_i = 1'b0;
  logic       ackrx;
  logic [3:0] last_dat;
  logic [7:0] rx_cnt;
  logic [7:0] err_cnt;
  logic       err_flag;

  int compared = 0;
  int mismatched = 0;

  ydevice_rx dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .validrx (validrx),
    .dat_o   (dat_o),
    .ackrx   (ackrx),
    .hold_i  (hold_i),
    .last_dat(last_dat),
    .rx_cnt  (rx_cnt),
    .err_cnt (err_cnt),
    .err_flag(err_flag)
  );

  always #5 clk_i = ~clk_i;

  // Model: a word is taken when offered, not held, and at least 3 edges after the previous take.
  int         cyc = 0;
  int         last_acc = -100;
  logic       m_ack = 1'b0;
  logic [3:0] m_last = 4'h0;
  int         m_rx = 0;
  int         m_err = 0;
  logic       m_flag = 1'b0;
  logic       m_seqv = 1'b0;
  logic [3:0] m_exp = 4'h0;

  always @(posedge clk_i) begin
    cyc++;
    if (rst_i) begin
      m_ack = 1'b0; m_last = 4'h0; m_rx = 0; m_err = 0;
      m_flag = 1'b0; m_seqv = 1'b0; last_acc = -100;
    end else begin
      m_ack = 1'b0;
      if (validrx && !hold_i && (cyc - last_acc >= 3)) begin
        last_acc = cyc;
        m_ack = 1'b1;
        m_last = dat_o;
        if (m_rx < 255) m_rx++;
        if (m_seqv && dat_o != m_exp) begin
          if (m_err < 255) m_err++;
          m_flag = 1'b1;
        end
        m_seqv = 1'b1;
        m_exp = dat_o + 4'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk_i) begin
    if (cyc > 0) begin
      chk("ackrx", {31'd0, ackrx}, {31'd0, m_ack});
      chk("last_dat", {28'd0, last_dat}, {28'd0, m_last});
      chk("rx_cnt", {24'd0, rx_cnt}, m_rx);
      chk("err_cnt", {24'd0, err_cnt}, m_err);
      chk("err_flag", {31'd0, err_flag}, {31'd0, m_flag});
    end
  end

  task automatic do_reset();
    rst_i = 1'b1; validrx = 1'b0; hold_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic send(input logic [3:0] w, output int n);
    dat_o = w; validrx = 1'b1; n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (ackrx !== 1'b1 && n < 20);
    chk("ack_seen", {31'd0, ackrx}, 32'd1);
  endtask

  initial begin
    int n;
    logic [3:0] w;

    // Reset state and single-word latency
    do_reset();
    chk("rst_rx_cnt", {24'd0, rx_cnt}, 32'd0);
    chk("rst_ackrx", {31'd0, ackrx}, 32'd0);
    dat_o = 4'h3; validrx = 1'b1;
    @(negedge clk_i);
    chk("t1_ack", {31'd0, ackrx}, 32'd1);
    chk("t1_last", {28'd0, last_dat}, 32'd3);
    chk("t1_rx", {24'd0, rx_cnt}, 32'd1);
    chk("t1_err", {24'd0, err_cnt}, 32'd0);
    chk("t1_model_rx", m_rx, 32'd1);
    validrx = 1'b0;
    @(negedge clk_i);
    chk("t1_ack_low1", {31'd0, ackrx}, 32'd0);
    @(negedge clk_i);
    chk("t1_ack_low2", {31'd0, ackrx}, 32'd0);

    // Back-to-back stream: pulses spaced exactly 3 cycles
    do_reset();
    send(4'h3, n);
    for (int i = 4; i <= 6; i++) begin
      w = 4'(i);
      send(w, n);
      chk("t2_spacing", n, 32'd3);
    end
    validrx = 1'b0;
    chk("t2_rx", {24'd0, rx_cnt}, 32'd4);
    chk("t2_err", {24'd0, err_cnt}, 32'd0);
    chk("t2_last", {28'd0, last_dat}, 32'd6);

    // Wrap 15 -> 0 is legal
    do_reset();
    send(4'hE, n); send(4'hF, n); send(4'h0, n); send(4'h1, n);
    validrx = 1'b0;
    chk("t3_rx", {24'd0, rx_cnt}, 32'd4);
    chk("t3_err", {24'd0, err_cnt}, 32'd0);
    chk("t3_flag", {31'd0, err_flag}, 32'd0);

    // Error at 7, resync at 8
    do_reset();
    send(4'h2, n); send(4'h3, n); send(4'h7, n);
    chk("t4_err_at7", {24'd0, err_cnt}, 32'd1);
    chk("t4_flag", {31'd0, err_flag}, 32'd1);
    chk("t4_model_err", m_err, 32'd1);
    send(4'h8, n);
    chk("t4_err_at8", {24'd0, err_cnt}, 32'd1);

    // Hold blocks acceptance; release gives ack one cycle later
    hold_i = 1'b1; dat_o = 4'h9;
    repeat (10) begin
      @(negedge clk_i);
    end
    chk("t5_ack_held", {31'd0, ackrx}, 32'd0);
    chk("t5_rx_held", {24'd0, rx_cnt}, 32'd4);
    hold_i = 1'b0;
    @(negedge clk_i);
    chk("t5_ack_release", {31'd0, ackrx}, 32'd1);
    chk("t5_rx", {24'd0, rx_cnt}, 32'd5);
    chk("t5_err", {24'd0, err_cnt}, 32'd1);

    // Reset while in ACK abandons everything
    do_reset();
    send(4'h5, n);
    rst_i = 1'b1; validrx = 1'b0;
    @(negedge clk_i);
    chk("t6_ack", {31'd0, ackrx}, 32'd0);
    chk("t6_rx", {24'd0, rx_cnt}, 32'd0);
    chk("t6_err", {24'd0, err_cnt}, 32'd0);
    rst_i = 1'b0;
    send(4'hC, n);
    validrx = 1'b0;
    chk("t6_first_err", {24'd0, err_cnt}, 32'd0);
    chk("t6_first_rx", {24'd0, rx_cnt}, 32'd1);

    // rx_cnt saturates at 255
    do_reset();
    for (int i = 0; i < 260; i++) begin
      w = 4'(i);
      send(w, n);
    end
    validrx = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("t7_rx_sat", {24'd0, rx_cnt}, 32'd255);
    chk("t7_err", {24'd0, err_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
